// File: rtl/board_io_pkg.sv
// Shared constants for the board push-button / difficulty interface.
// Button bit positions and the difficulty codes seen by the processor.
package board_io_pkg;

  localparam logic [1:0] DIFF_NONE = 2'd0;
  localparam logic [1:0] DIFF_EASY = 2'd1;
  localparam logic [1:0] DIFF_MED  = 2'd2;
  localparam logic [1:0] DIFF_HARD = 2'd3;

  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_C = 1;
  localparam int unsigned BTN_R = 2;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_U = 4;

  // L > C > R priority; U and D never select a difficulty.
  function automatic logic [1:0] encode_difficulty(input logic [4:0] btns);
    if (btns[BTN_L]) begin
      return DIFF_EASY;
    end else if (btns[BTN_C]) begin
      return DIFF_MED;
    end else if (btns[BTN_R]) begin
      return DIFF_HARD;
    end
    return DIFF_NONE;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One push-button: two-flop synchronizer, stability counter, debounced level
// and a registered one-cycle pulse on each accepted rising edge.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            st_q, st_d;
  logic            st_dly_q, st_dly_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    st_d     = st_q;
    cnt_d    = cnt_q;
    st_dly_d = st_q;
    press_d  = st_q & ~st_dly_q;
    // Any agreement with the stable value restarts the count.
    if (s2_q == st_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      st_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      st_q     <= 1'b0;
      st_dly_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      st_q     <= st_d;
      st_dly_q <= st_dly_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = st_q;
  assign press = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the five board buttons and drives the processor difficulty word,
// either following held buttons (level mode) or latching the last press.
module button_conditioner
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          STICKY          = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        BTNL,
  input  logic        BTNC,
  input  logic        BTNR,
  input  logic        BTNU,
  input  logic        BTND,
  output logic [4:0]  btn_level,
  output logic [4:0]  btn_press,
  output logic [31:0] difficulty
);

  logic [1:0] diff_q, diff_d;

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell_l (
    .clock(clock), .reset(reset), .raw(BTNL),
    .level(btn_level[BTN_L]), .press(btn_press[BTN_L])
  );
  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell_c (
    .clock(clock), .reset(reset), .raw(BTNC),
    .level(btn_level[BTN_C]), .press(btn_press[BTN_C])
  );
  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell_r (
    .clock(clock), .reset(reset), .raw(BTNR),
    .level(btn_level[BTN_R]), .press(btn_press[BTN_R])
  );
  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell_d (
    .clock(clock), .reset(reset), .raw(BTND),
    .level(btn_level[BTN_D]), .press(btn_press[BTN_D])
  );
  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell_u (
    .clock(clock), .reset(reset), .raw(BTNU),
    .level(btn_level[BTN_U]), .press(btn_press[BTN_U])
  );

  always_comb begin
    diff_d = diff_q;
    if (STICKY == 1'b0) begin
      diff_d = encode_difficulty(btn_level);
    end else if (btn_press[BTN_D]) begin
      // Clearing wins over any selection pressed in the same cycle.
      diff_d = DIFF_NONE;
    end else if (|btn_press[BTN_R:BTN_L]) begin
      diff_d = encode_difficulty(btn_press);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      diff_q <= DIFF_NONE;
    end else begin
      diff_q <= diff_d;
    end
  end

  assign difficulty = {30'd0, diff_q};

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, covering level
// mode (dut0) and latched mode (dut1) driven from the same button pins.
module tb_button_conditioner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btnl = 1'b0, btnc = 1'b0, btnr = 1'b0, btnu = 1'b0, btnd = 1'b0;
  logic [4:0]  lvl0, prs0, lvl1, prs1;
  logic [31:0] diff0, diff1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .STICKY(1'b0)) dut0 (
    .clock(clock), .reset(reset),
    .BTNL(btnl), .BTNC(btnc), .BTNR(btnr), .BTNU(btnu), .BTND(btnd),
    .btn_level(lvl0), .btn_press(prs0), .difficulty(diff0)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(4), .STICKY(1'b1)) dut1 (
    .clock(clock), .reset(reset),
    .BTNL(btnl), .BTNC(btnc), .BTNR(btnr), .BTNU(btnu), .BTND(btnd),
    .btn_level(lvl1), .btn_press(prs1), .difficulty(diff1)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    checks++;
    if (lvl0 !== 5'd0 || prs0 !== 5'd0 || diff0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_dut0: got lvl=%b prs=%b diff=%0d, need all 0", lvl0, prs0, diff0);
    end
    checks++;
    if (lvl1 !== 5'd0 || prs1 !== 5'd0 || diff1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_dut1: got lvl=%b prs=%b diff=%0d, need all 0", lvl1, prs1, diff1);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    logic [4:0]  el, ep;
    logic [31:0] ed;
    btnc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      el = (k >= 5) ? 5'b00010 : 5'd0;
      ep = (k == 6) ? 5'b00010 : 5'd0;
      ed = (k >= 6) ? 32'd2 : 32'd0;
      checks++;
      if (lvl0 !== el) begin
        errors++;
        $display("FAIL clean_level k=%0d: got %b need %b", k, lvl0, el);
      end
      checks++;
      if (prs0 !== ep) begin
        errors++;
        $display("FAIL clean_press k=%0d: got %b need %b", k, prs0, ep);
      end
      checks++;
      if (diff0 !== ed) begin
        errors++;
        $display("FAIL clean_diff k=%0d: got %0d need %0d", k, diff0, ed);
      end
    end
    btnc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      el = (k < 5) ? 5'b00010 : 5'd0;
      ed = (k < 6) ? 32'd2 : 32'd0;
      checks++;
      if (lvl0 !== el || prs0 !== 5'd0 || diff0 !== ed) begin
        errors++;
        $display("FAIL clean_release k=%0d: got lvl=%b prs=%b diff=%0d need lvl=%b prs=0 diff=%0d",
                 k, lvl0, prs0, diff0, el, ed);
      end
    end
  endtask

  task automatic test_glitch();
    btnl = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 2) btnl = 1'b0;
      checks++;
      if (lvl0 !== 5'd0 || prs0 !== 5'd0 || diff0 !== 32'd0) begin
        errors++;
        $display("FAIL glitch k=%0d: got lvl=%b prs=%b diff=%0d need all 0", k, lvl0, prs0, diff0);
      end
    end
    checks++;
    if (dut0.u_cell_l.cnt_q !== 3'd0) begin
      errors++;
      $display("FAIL glitch_cnt: got %0d need 0", dut0.u_cell_l.cnt_q);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    int         pulses;
    pat    = 5'b10101;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      btnr = pat[i];
      step();
      if (prs0[2]) pulses++;
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      if (prs0[2]) pulses++;
      checks++;
      if (prs0[2] !== (k == 6)) begin
        errors++;
        $display("FAIL bounce_press k=%0d: got %b need %b", k, prs0[2], (k == 6));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bounce_pulses: got %0d need 1", pulses);
    end
    checks++;
    if (diff0 !== 32'd3) begin
      errors++;
      $display("FAIL bounce_diff: got %0d need 3", diff0);
    end
    btnr = 1'b0;
    idle(12);
  endtask

  task automatic test_simultaneous();
    btnl = 1'b1;
    btnr = 1'b1;
    idle(7);
    checks++;
    if (diff0 !== 32'd1) begin
      errors++;
      $display("FAIL simul_diff: got %0d need 1", diff0);
    end
    btnl = 1'b0;
    idle(6);
    checks++;
    if (diff0 !== 32'd1) begin
      errors++;
      $display("FAIL simul_before_latency: got %0d need 1", diff0);
    end
    step();
    checks++;
    if (diff0 !== 32'd3) begin
      errors++;
      $display("FAIL simul_release_l: got %0d need 3", diff0);
    end
    btnr = 1'b0;
    idle(12);
  endtask

  task automatic test_latched();
    reset = 1'b1;
    step();
    reset = 1'b0;
    btnc = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (diff1 !== ((k >= 7) ? 32'd2 : 32'd0)) begin
        errors++;
        $display("FAIL latch_c k=%0d: got %0d need %0d", k, diff1, (k >= 7) ? 2 : 0);
      end
    end
    btnc = 1'b0;
    idle(12);
    checks++;
    if (diff1 !== 32'd2 || lvl1 !== 5'd0) begin
      errors++;
      $display("FAIL latch_hold: got diff=%0d lvl=%b need diff=2 lvl=0", diff1, lvl1);
    end
    btnd = 1'b1;
    btnl = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 6) begin
        checks++;
        if (prs1 !== 5'b01001) begin
          errors++;
          $display("FAIL latch_dl_press: got %b need 01001", prs1);
        end
      end
      checks++;
      if (diff1 !== ((k >= 7) ? 32'd0 : 32'd2)) begin
        errors++;
        $display("FAIL latch_dl k=%0d: got %0d need %0d", k, diff1, (k >= 7) ? 0 : 2);
      end
    end
    btnd = 1'b0;
    btnl = 1'b0;
    idle(12);
  endtask

  task automatic test_reset_mid();
    btnl = 1'b1;
    idle(4);
    reset = 1'b1;
    step();
    checks++;
    if (lvl0 !== 5'd0 || prs0 !== 5'd0 || diff0 !== 32'd0 || dut0.u_cell_l.cnt_q !== 3'd0) begin
      errors++;
      $display("FAIL midreset_clear: got lvl=%b prs=%b diff=%0d cnt=%0d need all 0",
               lvl0, prs0, diff0, dut0.u_cell_l.cnt_q);
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (prs0[0] !== (k == 6) || lvl0[0] !== (k >= 5)) begin
        errors++;
        $display("FAIL midreset_relatch k=%0d: got prs=%b lvl=%b need prs=%b lvl=%b",
                 k, prs0[0], lvl0[0], (k == 6), (k >= 5));
      end
    end
    checks++;
    if (diff0 !== 32'd1) begin
      errors++;
      $display("FAIL midreset_diff: got %0d need 1", diff0);
    end
    btnl = 1'b0;
    idle(12);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_latched();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
